// File: rtl/testport_capture.sv
// Snoops data-memory stores to the test port, frames them between BEGIN_SYM and END_SYM and
// buffers readable-order words in a FIFO. Optional per-word cycle stamps: TESTPORT_TIMESTAMP_EN.
module testport_capture #(
  parameter logic [29:0] TEST_PORT  = 30'h10,
  parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
  parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [15:0] out_stamp,
  input  logic        out_ready,
  output logic        active,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } state_e;

  state_e          state_q;
  logic            wen_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     data_mem [FIFO_DEPTH];

  logic [31:0]     swapped;
  logic            wr_event, begin_hit, push, pop, accept;
  logic [CntW-1:0] remain;
  logic [PtrW-1:0] head_ptr;

  assign swapped   = {data[7:0], data[15:8], data[23:16], data[31:24]};
  assign wr_event  = wen && !wen_q && (addr == TEST_PORT);
  assign begin_hit = (state_q == StIdle) && wr_event && (swapped == BEGIN_SYM);
  assign push      = wr_event && (state_q == StCapture);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept    = push && ((count_q != Full) || pop);

  // Head registers follow pops immediately but see pushes one cycle later.
  assign remain    = count_q - CntW'(pop);
  assign head_ptr  = rd_ptr_q + PtrW'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      wen_q      <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= 8'd0;
    end else begin
      wen_q <= wen;
      if (push && !accept) overflow <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (begin_hit) begin
            state_q    <= StCapture;
            active     <= 1'b1;
            word_count <= 8'd0;
          end
        end
        StCapture: begin
          if (push) begin
            if (word_count != 8'hFF) word_count <= word_count + 8'd1;
            if (swapped == END_SYM) begin
              state_q <= StDone;
              active  <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q   <= count_q + CntW'(accept) - CntW'(pop);
      out_valid <= (remain != '0);
      out_data  <= (remain != '0) ? data_mem[head_ptr] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_mem[wr_ptr_q] <= swapped;
  end

`ifdef TESTPORT_TIMESTAMP_EN
  logic [15:0] stamp_q, stamp_d;
  logic [15:0] stamp_mem [FIFO_DEPTH];

  // A word carries the counter value reached at its push edge.
  always_comb begin
    stamp_d = stamp_q;
    if (begin_hit) begin
      stamp_d = 16'h0000;
    end else if (state_q == StCapture) begin
      stamp_d = stamp_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stamp_q   <= 16'h0000;
      out_stamp <= 16'h0000;
    end else begin
      stamp_q   <= stamp_d;
      out_stamp <= (remain != '0) ? stamp_mem[head_ptr] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) stamp_mem[wr_ptr_q] <= stamp_d;
  end
`else
  assign out_stamp = 16'h0000;
`endif

endmodule

// File: tb/tb_testport_capture.sv
// Directed self-checking bench for testport_capture (default parameters, depth 8).
module tb_testport_capture;

  localparam logic [29:0] Tp = 30'h10;
`ifdef TESTPORT_TIMESTAMP_EN
  localparam bit StampOn = 1'b1;
`else
  localparam bit StampOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wen, out_ready;
  logic [29:0] addr;
  logic [31:0] data;
  logic        out_valid, active, done, overflow;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic [7:0]  word_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  testport_capture dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data       (data),
    .wen        (wen),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_stamp  (out_stamp),
    .out_ready  (out_ready),
    .active     (active),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  // Every accepted head word, as seen just before the edge that pops it.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [29:0] a, input logic [31:0] d);
    addr = a;
    data = d;
    wen  = 1'b1;
    tick();
    wen  = 1'b0;
    tick();
  endtask

  // Bus word whose readable form is 32'h000000nn.
  function automatic logic [31:0] bus_of(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_stamp"}, 32'(out_stamp), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_q(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (i < got_q.size()) ? got_q[i] : 32'bx, exp_q[i]);
    end
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; out_ready = 1'b0; addr = '0; data = '0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Filtering: wrong address, and data before a frame opens.
    write(30'h11, 32'h68010000);
    check("filt_addr_active", 32'(active), 32'd0);
    write(Tp, 32'hADDE0000);
    check("filt_pre_active", 32'(active), 32'd0);
    check("filt_pre_valid", 32'(out_valid), 32'd0);

    // Basic frame with a free-running consumer.
    got_q.delete();
    out_ready = 1'b1;
    write(Tp, 32'h68010000);
    check("basic_active", 32'(active), 32'd1);
    check("basic_count0", 32'(word_count), 32'd0);
    write(Tp, 32'hADDE0000);
    write(Tp, 32'h20F60000);
    write(Tp, 32'h5DFDFFFF);
    check("basic_done", 32'(done), 32'd1);
    check("basic_inactive", 32'(active), 32'd0);
    check("basic_count", 32'(word_count), 32'd3);
    repeat (3) tick();
    exp_q = '{32'h0000DEAD, 32'h0000F620, 32'hFFFFFD5D};
    check_q("basic_seq");
    write(Tp, 32'hADDE0000);
    repeat (3) tick();
    check("post_done_len", 32'(got_q.size()), 32'd3);
    check("post_done_count", 32'(word_count), 32'd3);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    check("rst_done", 32'(done), 32'd0);

    // Frame 2: BEGIN at edge 0, data events at edges 3 and 10 (the latter a 5-cycle stall).
    addr = Tp; data = 32'h68010000; wen = 1'b1;
    tick();
    wen = 1'b0;
    check("f2_active", 32'(active), 32'd1);
    tick();
    tick();
    data = 32'h01000000; wen = 1'b1;
    tick();
    wen = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'h00000001);
    check("stamp_first", 32'(out_stamp), StampOn ? 32'd3 : 32'd0);
    repeat (5) tick();
    data = 32'h00806F56; wen = 1'b1;
    repeat (5) tick();
    wen = 1'b0;
    tick();
    check("stall_count", 32'(word_count), 32'd2);
    out_ready = 1'b1;
    tick();
    check("stall_data", out_data, 32'h566F8000);
    check("stamp_second", 32'(out_stamp), StampOn ? 32'd10 : 32'd0);
    tick();
    check("last_pop_valid", 32'(out_valid), 32'd0);
    check("last_pop_data", out_data, 32'd0);
    out_ready = 1'b0;

    // Backpressure: fill to 8, push+pop while full, then overflow on the next push.
    for (int i = 1; i <= 8; i++) write(Tp, bus_of(8'(8'hA0 + i)));
    check("full_no_ovf", 32'(overflow), 32'd0);
    check("full_head", out_data, 32'h000000A1);
    addr = Tp; data = bus_of(8'hB0); wen = 1'b1; out_ready = 1'b1;
    tick();
    wen = 1'b0; out_ready = 1'b0;
    check("pushpop_ovf", 32'(overflow), 32'd0);
    check("pushpop_head", out_data, 32'h000000A2);
    tick();
    write(Tp, bus_of(8'hA9));
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(word_count), 32'd12);

    got_q.delete();
    out_ready = 1'b1;
    repeat (10) tick();
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 2; i <= 8; i++) exp_q.push_back(32'(8'(8'hA0 + i)));
    exp_q.push_back(32'h000000B0);
    check_q("drain");

    got_q.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) write(Tp, bus_of(8'(8'hC0 + i)));
    repeat (3) tick();
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(8'(8'hC0 + i)));
    check_q("wrap");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with 4 words buffered, then a fresh frame.
    for (int i = 1; i <= 4; i++) write(Tp, bus_of(8'(8'hD0 + i)));
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_vals("midrst");
    got_q.delete();
    out_ready = 1'b1;
    write(Tp, 32'h68010000);
    check("fresh_active", 32'(active), 32'd1);
    check("fresh_valid", 32'(out_valid), 32'd0);
    write(Tp, bus_of(8'hE1));
    repeat (2) tick();
    exp_q = '{32'h000000E1};
    check_q("fresh");
    check("fresh_count", 32'(word_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
